// File: rtl/fifo_serial_reader_pkg.sv
// Shared definitions for the FIFO serial reader: FSM state encoding and counter sizing.
package fifo_ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_serial_reader_if.sv
// FIFO read port plus serial link signals of the FIFO serial reader.
interface fifo_serial_reader_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
);

  logic                 enable;
  logic                 fifo_empty;
  logic [WIDTH-1:0]     fifo_data;
  logic                 fifo_read_enable;
  logic                 ser_data;
  logic                 ser_valid;
  logic                 ser_frame;
  logic                 busy;
  logic [CNT_WIDTH-1:0] words_sent;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_read_enable, ser_data, ser_valid, ser_frame, busy, words_sent
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_read_enable, ser_data, ser_valid, ser_frame, busy, words_sent
  );

endinterface

// File: rtl/fifo_serial_reader_tick.sv
// Bit-period divider: counts 0..BIT_DIV-1 while running and pulses on the terminal count.
module ser_bit_tick
  import fifo_ser_pkg::*;
#(
  parameter int BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick
);

  localparam int            DW   = cntWidth(BIT_DIV);
  localparam logic [DW-1:0] TERM = DW'(BIT_DIV - 1);

  logic [DW-1:0] r_divCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt <= '0;
    end else if (i_clear) begin
      r_divCnt <= '0;
    end else if (i_run) begin
      r_divCnt <= (r_divCnt == TERM) ? '0 : r_divCnt + DW'(1);
    end
  end

  // With BIT_DIV=1 the counter stays at zero and the tick fires every running cycle.
  assign o_tick = i_run && (r_divCnt == TERM);

endmodule

// File: rtl/fifo_serial_reader.sv
// Pops words from the synchronous FIFO and shifts them out MSB-first, BIT_DIV clocks per bit,
// counting completed words.
module fifo_serial_reader
  import fifo_ser_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BIT_DIV   = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_serial_reader_if.master  io_bus
);

  localparam int            BW       = cntWidth(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_shreg;
  logic [BW-1:0]        r_bitCnt;
  logic [CNT_WIDTH-1:0] r_wordCnt;
  logic                 w_tick;
  logic                 w_endOfWord;
  logic                 w_fetchOk;

  ser_bit_tick #(.BIT_DIV(BIT_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == S_LOAD),
    .i_run   (r_state == S_SHIFT),
    .o_tick  (w_tick)
  );

  assign w_fetchOk   = io_bus.enable && !io_bus.fifo_empty;
  assign w_endOfWord = (r_state == S_SHIFT) && w_tick && (r_bitCnt == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Enable and FIFO status only matter in IDLE and on the last cycle of a word.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_fetchOk) w_next = S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_endOfWord) w_next = w_fetchOk ? S_FETCH : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bitCnt  <= '0;
      r_wordCnt <= '0;
    end else begin
      if (r_state == S_LOAD) begin
        r_shreg  <= io_bus.fifo_data;
        r_bitCnt <= '0;
      end else if ((r_state == S_SHIFT) && w_tick) begin
        r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
        r_bitCnt <= r_bitCnt + BW'(1);
      end
      if (w_endOfWord) begin
        r_wordCnt <= r_wordCnt + CNT_WIDTH'(1);
      end
    end
  end

  assign io_bus.fifo_read_enable = (r_state == S_FETCH);
  assign io_bus.ser_valid        = (r_state == S_SHIFT);
  assign io_bus.ser_data         = (r_state == S_SHIFT) && r_shreg[WIDTH-1];
  assign io_bus.ser_frame        = (r_state == S_SHIFT) && (r_bitCnt == '0);
  assign io_bus.busy             = (r_state != S_IDLE);
  assign io_bus.words_sent       = r_wordCnt;

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Scoreboard bench for fifo_serial_reader: a timeline reference model predicts every output cycle,
// plus a second instance exercising BIT_DIV=1 with a 2-bit word counter.
module tb_fifo_serial_reader;

  localparam int WIDTH     = 16;
  localparam int BIT_DIV   = 4;
  localparam int CNT_WIDTH = 8;
  localparam int WD        = WIDTH * BIT_DIV;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_serial_reader_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();
  fifo_serial_reader_if #(.WIDTH(WIDTH), .CNT_WIDTH(2))         bus2 ();

  fifo_serial_reader #(.WIDTH(WIDTH), .BIT_DIV(BIT_DIV), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.master)
  );

  fifo_serial_reader #(.WIDTH(WIDTH), .BIT_DIV(1), .CNT_WIDTH(2)) dutSmall (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus2.master)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fifoQ[$];
  logic [WIDTH-1:0] expQ[$];
  logic             readReq;

  int                   cyc         = 0;
  int                   validStart  = -1000;
  int                   busyUntil   = -1;
  int                   readAt      = -1;
  int                   refDecision = 0;
  int                   k;
  logic [WIDTH-1:0]     curWord     = '0;
  logic [CNT_WIDTH-1:0] refSent     = '0;
  logic                 expValid;
  logic                 expData;
  logic                 expFrame;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural FIFO: a pop requested in one cycle presents its data after the next edge.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      readReq = bus.fifo_read_enable;
      @(posedge clk);
      #1;
      if (readReq) begin
        checkOutput("popNonEmpty", 32'(fifoQ.size() != 0), 32'd1);
        if (fifoQ.size() != 0) bus.fifo_data = fifoQ.pop_front();
      end
      bus.fifo_empty = (fifoQ.size() == 0);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] word);
    fifoQ.push_back(word);
    expQ.push_back(word);
    bus.fifo_empty = 1'b0;
  endtask

  // Reference timeline: a decision taken at cycle c pops at c+1 and shifts in c+3..c+2+WD,
  // after which the next decision happens on the word's last cycle.
  always @(negedge clk) begin
    if (rst) begin
      validStart  = -1000;
      busyUntil   = -1;
      readAt      = -1;
      refDecision = 0;
      refSent     = '0;
      checkOutput("rstValid", 32'(bus.ser_valid), 32'd0);
      checkOutput("rstData", 32'(bus.ser_data), 32'd0);
      checkOutput("rstFrame", 32'(bus.ser_frame), 32'd0);
      checkOutput("rstBusy", 32'(bus.busy), 32'd0);
      checkOutput("rstRead", 32'(bus.fifo_read_enable), 32'd0);
      checkOutput("rstWords", 32'(bus.words_sent), 32'd0);
    end else begin
      k        = cyc - validStart;
      expValid = (k >= 0) && (k < WD);
      expData  = 1'b0;
      expFrame = 1'b0;
      if (expValid) begin
        expData  = curWord[WIDTH-1-(k/BIT_DIV)];
        expFrame = (k < BIT_DIV);
      end
      checkOutput("serValid", 32'(bus.ser_valid), 32'(expValid));
      checkOutput("serData", 32'(bus.ser_data), 32'(expData));
      checkOutput("serFrame", 32'(bus.ser_frame), 32'(expFrame));
      checkOutput("busy", 32'(bus.busy), 32'(cyc <= busyUntil));
      checkOutput("readPulse", 32'(bus.fifo_read_enable), 32'(cyc == readAt));
      checkOutput("wordsSent", 32'(bus.words_sent), 32'(refSent));
      if (expValid && (k == WD - 1)) refSent++;
      if (cyc >= refDecision) begin
        if (bus.enable && !bus.fifo_empty) begin
          curWord     = (expQ.size() != 0) ? expQ.pop_front() : '0;
          readAt      = cyc + 1;
          validStart  = cyc + 3;
          busyUntil   = cyc + 2 + WD;
          refDecision = cyc + 2 + WD;
        end else begin
          refDecision = cyc + 1;
        end
      end
    end
    cyc++;
  end

  // Five words through the BIT_DIV=1, CNT_WIDTH=2 instance: 16-cycle words, 2-cycle gaps, wrapping count.
  task automatic runSmallCounterTest();
    logic [WIDTH-1:0] q2[$];
    logic [WIDTH-1:0] e2[$];
    logic [WIDTH-1:0] cur2   = '0;
    logic [WIDTH-1:0] w;
    int               run    = 0;
    int               gap    = 0;
    int               seen   = 0;
    bit               pend2;
    bit               cntDue = 1'b0;
    int               expSeq[5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      w = WIDTH'($urandom);
      q2.push_back(w);
      e2.push_back(w);
    end
    bus2.fifo_empty = 1'b0;
    bus2.enable     = 1'b1;
    for (int c2 = 0; c2 < 200 && !(seen == 5 && gap > 2); c2++) begin
      @(negedge clk);
      if (cntDue) begin
        checkOutput("smallWordCount", 32'(bus2.words_sent), 32'(expSeq[seen-1]));
        cntDue = 1'b0;
      end
      pend2 = bus2.fifo_read_enable;
      if (bus2.ser_valid) begin
        if (run == 0) begin
          if (seen > 0) checkOutput("smallGap", 32'(gap), 32'd2);
          if (e2.size() != 0) cur2 = e2.pop_front();
        end
        checkOutput("smallData", 32'(bus2.ser_data), 32'(cur2[WIDTH-1-run]));
        run++;
        gap = 0;
        if (run == WIDTH) begin
          run    = 0;
          seen++;
          cntDue = 1'b1;
        end
      end else begin
        if (run != 0) begin
          checkOutput("smallRunLength", 32'(run), 32'(WIDTH));
          run = 0;
        end
        gap++;
      end
      @(posedge clk);
      #1;
      if (pend2 && q2.size() != 0) bus2.fifo_data = q2.pop_front();
      bus2.fifo_empty = (q2.size() == 0);
    end
    checkOutput("smallWordsSeen", 32'(seen), 32'd5);
  endtask

  initial begin
    rst             = 1'b0;
    bus.enable      = 1'b0;
    bus.fifo_empty  = 1'b1;
    bus.fifo_data   = '0;
    bus2.enable     = 1'b0;
    bus2.fifo_empty = 1'b1;
    bus2.fifo_data  = '0;

    #3 rst = 1'b1;
    #1;
    checkOutput("asyncRstValid", 32'(bus.ser_valid), 32'd0);
    checkOutput("asyncRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("asyncRstWords", 32'(bus.words_sent), 32'd0);
    stepCycles(2);
    #2 rst = 1'b0;
    bus.enable = 1'b1;
    stepCycles(10);

    applyStimulus(16'hA5C3);
    stepCycles(80);
    checkOutput("singleWordCount", 32'(bus.words_sent), 32'd1);

    applyStimulus(16'h8001);
    applyStimulus(16'h7FFE);
    stepCycles(150);
    checkOutput("twoWordCount", 32'(bus.words_sent), 32'd3);

    // Enable drops at bit 5 of the first of three queued words.
    applyStimulus(16'h1234);
    applyStimulus(16'h5678);
    applyStimulus(16'h9ABC);
    stepCycles(24);
    bus.enable = 1'b0;
    stepCycles(100);
    checkOutput("enableDropCount", 32'(bus.words_sent), 32'd4);
    checkOutput("enableDropLeft", 32'(fifoQ.size()), 32'd2);
    checkOutput("enableDropIdle", 32'(bus.busy), 32'd0);

    // Async reset in bit 7 of a word; the next queued word must follow after release.
    bus.enable = 1'b1;
    stepCycles(32);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstValid", 32'(bus.ser_valid), 32'd0);
    checkOutput("midRstData", 32'(bus.ser_data), 32'd0);
    checkOutput("midRstWords", 32'(bus.words_sent), 32'd0);
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    stepCycles(2);
    #2 rst = 1'b0;
    stepCycles(80);
    checkOutput("postRstCount", 32'(bus.words_sent), 32'd1);
    checkOutput("postRstDrained", 32'(fifoQ.size()), 32'd0);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) applyStimulus(WIDTH'($urandom));
      bus.enable = 1'($urandom_range(0, 1));
      stepCycles($urandom_range(5, 60));
    end
    bus.enable = 1'b1;
    stepCycles(1700);
    checkOutput("randomDrained", 32'(expQ.size()), 32'd0);
    checkOutput("randomIdle", 32'(bus.busy), 32'd0);

    runSmallCounterTest();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
